rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 The block SHALL have no parameters; it SHALL serve exactly 8 requesters and hold timeout at 16 cycles.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  8  request vector; bit i high = requester i wants the resource; any number of bits may be high.
REQ-005 done  input  1  release strobe from the current owner; sampled only in BUSY.
REQ-006 grant  output  8  registered grant; SHALL be all-zero or exactly one-hot (never multi-hot), so it is a legal input to the downstream 8-to-3 encoder.
REQ-007 busy  output  1  registered; high exactly when grant is non-zero.
REQ-008 timeout  output  1  registered one-cycle pulse; high for the cycle after a forced release.

Function
REQ-009 The block SHALL implement two states, IDLE and BUSY, plus a 3-bit priority pointer ptr and a 4-bit hold counter cnt.
REQ-010 In IDLE with req == 8'h00, the block SHALL stay in IDLE with grant == 8'h00 and ptr unchanged.
REQ-011 In IDLE with req != 8'h00, the winner SHALL be the first set bit found scanning indices ptr, ptr+1, ... ptr+7 (mod 8).
REQ-012 For that case, on the next edge the block SHALL set grant to the winner's one-hot, enter BUSY and clear cnt to 0.
REQ-013 Grant latency SHALL be exactly one cycle from the cycle req is sampled non-zero in IDLE.
REQ-014 In BUSY, grant SHALL hold its value regardless of req changes, including the owner dropping its req bit.
REQ-015 In BUSY, each cycle without done SHALL increment cnt by 1.
REQ-016 In BUSY with done == 1, on the next edge grant SHALL go to 8'h00 and the state SHALL return to IDLE.
REQ-017 On that release, ptr SHALL become (owner index + 1) mod 8, so index 7 wraps to 0.
REQ-018 In BUSY with done == 0 and cnt == 15, on the next edge the block SHALL force a release: grant = 8'h00, state IDLE, ptr = (owner + 1) mod 8, timeout = 1 for one cycle.
REQ-019 If done == 1 in the same cycle as cnt == 15, it SHALL count as a normal release with timeout = 0.
REQ-020 Every release SHALL be followed by at least one IDLE cycle with grant == 8'h00 before the next grant (no back-to-back owners).
REQ-021 done sampled while in IDLE SHALL be ignored.
REQ-022 timeout SHALL be 0 on every cycle other than the one that follows a forced release.
REQ-023 grant == 8'h00 SHALL occur only in IDLE; busy SHALL equal (grant != 8'h00) every cycle.

Reset
REQ-024 With rst high at an edge, the block SHALL on that edge set state = IDLE, grant = 8'h00, busy = 0, timeout = 0, ptr = 0, cnt = 0.
REQ-025 Reset SHALL override all other inputs, including mid-BUSY: an active grant SHALL drop to 8'h00 on the reset edge with no timeout pulse.
REQ-026 On the first edge after rst deasserts, the block SHALL arbitrate normally from ptr = 0.

Verification
REQ-027 Single requester: after reset, req = 8'b00000100 -> next cycle grant = 8'b00000100, busy = 1; done pulse -> next cycle grant = 8'h00, ptr = 3.
REQ-028 Round-robin fairness: req held at 8'hFF, done pulsed once per grant -> grants in order bit0, bit1 ... bit7, then bit0 again, with one idle cycle between consecutive grants.
REQ-029 Pointer skip: ptr = 5, req = 8'b00001001 -> grant = 8'b00000001 (index 0 via wrap); after release ptr = 1, and the next arbitration grants index 3.
REQ-030 Timeout: grant bit 2, done held low 16 BUSY cycles -> grant = 8'h00 and timeout = 1 for exactly one cycle, ptr = 3; same run with done on the 16th cycle -> timeout stays 0.
REQ-031 Hold and reset: during BUSY, toggle req arbitrarily -> grant unchanged; assert rst mid-BUSY -> grant = 8'h00, ptr = 0 on that edge, timeout = 0.
REQ-032 Checker, every cycle: grant is 8'h00 or has exactly one bit set, and busy == (grant != 0).

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered one-hot grant.
// An owner keeps the grant until it pulses done_i or has held it for 16 cycles;
// a forced release raises timeout_o for one cycle. Each release is followed by at
// least one idle cycle, and priority rotates to the index after the last owner.
module rr_arbiter_8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic [7:0] grant_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [3:0] HoldMax = 4'd15;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [2:0] winner;
  logic       any_req;

  // Rotating priority scan: walk offsets from high to low so the smallest
  // offset from ptr_q overwrites the others and wins.
  always_comb begin
    winner  = ptr_q;
    any_req = |req_i;
    for (int k = 7; k >= 0; k--) begin
      if (req_i[ptr_q + 3'(k)]) begin
        winner = ptr_q + 3'(k);
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // done_i is deliberately ignored here.
        if (any_req) begin
          state_d = StBusy;
          owner_d = winner;
          grant_d = 8'b1 << winner;
          busy_d  = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      StBusy: begin
        // Grant is frozen while busy; req_i is not looked at.
        if (done_i || (cnt_q == HoldMax)) begin
          state_d   = StIdle;
          grant_d   = 8'h00;
          busy_d    = 1'b0;
          ptr_d     = owner_q + 3'd1;
          // A simultaneous done_i makes this a normal release.
          timeout_d = ~done_i;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= 3'd0;
      owner_q   <= 3'd0;
      cnt_q     <= 4'd0;
      grant_q   <= 8'h00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: a cycle-level reference model pushes the expected
// grant/busy/timeout for every driven cycle into a queue; each scenario task pops
// and compares after the edge, and adds directed checks on specific grants.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic       busy;
  logic       timeout;

  always #5 clk = ~clk;

  rr_arbiter_8 dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .done_i   (done),
    .grant_o  (grant),
    .busy_o   (busy),
    .timeout_o(timeout)
  );

  typedef struct packed {
    logic [7:0] g;
    logic       b;
    logic       t;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   vectors = 0;
  int   errors  = 0;

  // Reference model state
  logic       m_busy  = 1'b0;
  logic [2:0] m_ptr   = 3'd0;
  logic [2:0] m_owner = 3'd0;
  logic [3:0] m_cnt   = 4'd0;
  logic [7:0] m_grant = 8'h00;
  logic       m_to    = 1'b0;

  // Drive one cycle of inputs, predict the outputs after the edge, wait past it.
  task automatic drive(input logic r, input logic [7:0] rq, input logic d);
    bit found;
    int idx;
    rst  = r;
    req  = rq;
    done = d;
    m_to = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_ptr = 3'd0; m_cnt = 4'd0; m_grant = 8'h00;
    end else if (!m_busy) begin
      if (rq != 8'h00) begin
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
          idx = (int'(m_ptr) + i) % 8;
          if (!found && rq[idx]) begin
            found   = 1'b1;
            m_owner = idx[2:0];
          end
        end
        m_grant = 8'h01 << m_owner;
        m_busy  = 1'b1;
        m_cnt   = 4'd0;
      end
    end else if (d || m_cnt == 4'd15) begin
      m_to    = !d;
      m_busy  = 1'b0;
      m_grant = 8'h00;
      m_ptr   = m_owner + 3'd1;
    end else begin
      m_cnt = m_cnt + 4'd1;
    end
    exp_q.push_back('{m_grant, m_busy, m_to});
    @(posedge clk);
    #1;
  endtask

  // Every cycle: grant is zero or one-hot, busy tracks grant.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      vectors++;
      if (!$onehot0(grant) || (busy !== (grant != 8'h00))) begin
        errors++;
        $display("FAIL invariant: grant=%b busy=%b", grant, busy);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'hFF, 1'b1);
      e = exp_q.pop_front(); vectors++;
      if ({grant, busy, timeout} !== e) begin
        errors++;
        $display("FAIL reset: got g=%h b=%b t=%b want g=%h b=%b t=%b",
                 grant, busy, timeout, e.g, e.b, e.t);
      end
    end
    vectors++;
    if (grant !== 8'h00 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_const: got g=%h b=%b t=%b want 00 0 0", grant, busy, timeout);
    end
  endtask

  task automatic test_single();
    logic [7:0] want [6] = '{8'h04, 8'h04, 8'h00, 8'h00, 8'h08, 8'h00};
    logic [7:0] rq   [6] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h89, 8'h00};
    logic       dn   [6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
    // grant bit2, hold, release (ptr=3), done in idle ignored, bits{0,3,7} -> 3
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, rq[i], dn[i]);
      e = exp_q.pop_front(); vectors++;
      if ({grant, busy, timeout} !== e) begin
        errors++;
        $display("FAIL single[%0d]: got g=%h b=%b t=%b want g=%h b=%b t=%b",
                 i, grant, busy, timeout, e.g, e.b, e.t);
      end
      vectors++;
      if (grant !== want[i]) begin
        errors++;
        $display("FAIL single_grant[%0d]: got %h want %h", i, grant, want[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] want;
    drive(1'b1, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      want = 8'h01 << (k % 8);
      drive(1'b0, 8'hFF, 1'b0);
      e = exp_q.pop_front(); vectors++;
      if ({grant, busy, timeout} !== e || grant !== want) begin
        errors++;
        $display("FAIL fair_grant[%0d]: got g=%h b=%b want g=%h", k, grant, busy, want);
      end
      drive(1'b0, 8'hFF, 1'b1);
      e = exp_q.pop_front(); vectors++;
      if ({grant, busy, timeout} !== e || grant !== 8'h00) begin
        errors++;
        $display("FAIL fair_idle[%0d]: got g=%h b=%b t=%b want g=00", k, grant, busy, timeout);
      end
    end
  endtask

  task automatic test_pointer_skip();
    logic [7:0] rq   [5] = '{8'h10, 8'h00, 8'h09, 8'h00, 8'h09};
    logic       dn   [5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [7:0] want [5] = '{8'h10, 8'h00, 8'h01, 8'h00, 8'h08};
    drive(1'b1, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, rq[i], dn[i]);
      e = exp_q.pop_front(); vectors++;
      if ({grant, busy, timeout} !== e || grant !== want[i]) begin
        errors++;
        $display("FAIL skip[%0d]: got g=%h b=%b t=%b want g=%h", i, grant, busy, timeout, want[i]);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    void'(exp_q.pop_front());
  endtask

  task automatic test_timeout();
    logic [7:0] want_g;
    logic       want_t;
    drive(1'b1, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    // run 0: done never; run 1: done on the 16th busy cycle
    for (int run = 0; run < 2; run++) begin
      drive(1'b0, 8'h04, 1'b0);
      void'(exp_q.pop_front());
      for (int c = 1; c <= 16; c++) begin
        drive(1'b0, 8'hFF, (run == 1 && c == 16));
        e = exp_q.pop_front(); vectors++;
        want_g = (c == 16) ? 8'h00 : 8'h04;
        want_t = (c == 16 && run == 0);
        if ({grant, busy, timeout} !== e || grant !== want_g || timeout !== want_t) begin
          errors++;
          $display("FAIL timeout[%0d.%0d]: got g=%h t=%b want g=%h t=%b",
                   run, c, grant, timeout, want_g, want_t);
        end
      end
      drive(1'b0, 8'h00, 1'b0);
      e = exp_q.pop_front(); vectors++;
      if ({grant, busy, timeout} !== e || timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_pulse[%0d]: got t=%b want 0", run, timeout);
      end
      // ptr is now 3: bits {2,3} must pick 3
      drive(1'b0, 8'h0C, 1'b0);
      e = exp_q.pop_front(); vectors++;
      if ({grant, busy, timeout} !== e || grant !== 8'h08) begin
        errors++;
        $display("FAIL timeout_ptr[%0d]: got g=%h want 08", run, grant);
      end
      drive(1'b0, 8'h00, 1'b1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_hold_reset();
    drive(1'b1, 8'h00, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b0, 8'h40, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      e = exp_q.pop_front(); vectors++;
      if ({grant, busy, timeout} !== e || grant !== 8'h40) begin
        errors++;
        $display("FAIL hold[%0d]: got g=%h b=%b want g=40", i, grant, busy);
      end
    end
    drive(1'b1, 8'hFF, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if ({grant, busy, timeout} !== e || grant !== 8'h00 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got g=%h b=%b t=%b want 00 0 0", grant, busy, timeout);
    end
    // ptr back to 0: bits {0,7} must pick 0
    drive(1'b0, 8'h81, 1'b0);
    e = exp_q.pop_front(); vectors++;
    if ({grant, busy, timeout} !== e || grant !== 8'h01) begin
      errors++;
      $display("FAIL post_reset: got g=%h want 01", grant);
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_pointer_skip();
    test_timeout();
    test_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
